// File: rtl/ant_pkg.sv
// Shared widths, opcodes, state encodings and instruction builders for the
// multi-ant draw sequencer and its datapath requester.
package ant_pkg;

    localparam int DEF_NUM_ANTS = 8;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;
    localparam int DEF_INSTR_W  = 32;
    localparam int DEF_RESULT_W = 32;

    localparam logic [3:0] OP_DRAW = 4'd1;
    localparam logic [3:0] OP_LOAD = 4'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_Y,
        S_ERASE,
        S_DRAW,
        S_NEXT
    } draw_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_HOLD,
        R_WAIT
    } req_state_e;

    function automatic logic [DEF_INSTR_W-1:0] mk_load_instr(
        input logic [DEF_ADDR_W-1:0] addr
    );
        return {OP_LOAD, 12'd0, addr};
    endfunction

    // Bit 18 is the plot-enable flag the datapath expects on every draw.
    function automatic logic [DEF_INSTR_W-1:0] mk_plot_instr(
        input logic [DEF_COLOUR_W-1:0] colour,
        input logic [DEF_Y_W-1:0]      y,
        input logic [DEF_X_W-1:0]      x
    );
        return {OP_DRAW, 9'd0, 1'b1, colour, y, x};
    endfunction

endpackage

// File: rtl/ant_dp_requester.sv
// Generic ISSUE/HOLD/WAIT handshake onto the shared datapath port. A req pulse
// starts a transaction on the next cycle; done is asserted in the WAIT cycle that sees finished_dp.
module ant_dp_requester
    import ant_pkg::*;
#(
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int RESULT_W = DEF_RESULT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req,
    input  logic [INSTR_W-1:0]  instr,
    output logic                done,
    output logic [RESULT_W-1:0] result,
    output logic                start_dp,
    output logic [INSTR_W-1:0]  instruction_dp,
    input  logic                finished_dp,
    input  logic [RESULT_W-1:0] result_dp
);

    req_state_e         state_q, state_d;
    logic               start_dp_q, start_dp_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // req may arrive in the same cycle as done, giving back-to-back transactions.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        if (req) begin
            state_d = R_ISSUE;
            instr_d = instr;
        end else begin
            case (state_q)
                R_ISSUE: state_d = R_HOLD;
                R_HOLD:  state_d = R_WAIT;
                R_WAIT:  if (finished_dp) state_d = R_IDLE;
                default: state_d = state_q;
            endcase
        end
        start_dp_d = (state_d == R_ISSUE) || (state_d == R_HOLD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= R_IDLE;
            start_dp_q <= 1'b0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            start_dp_q <= start_dp_d;
            instr_q    <= instr_d;
        end
    end

    assign done           = (state_q == R_WAIT) && finished_dp;
    assign result         = result_dp;
    assign start_dp       = start_dp_q;
    assign instruction_dp = instr_q;

endmodule

// File: rtl/ant_swarm_draw.sv
// Multi-ant draw sequencer: per ant, load x and y, optionally erase the old
// pixel, then plot the new one, all through one shared datapath requester.
module ant_swarm_draw
    import ant_pkg::*;
#(
    parameter int NUM_ANTS = DEF_NUM_ANTS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int RESULT_W = DEF_RESULT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                finished,
    input  logic                erase_en,
    input  logic [COLOUR_W-1:0] ant_colour,
    input  logic [COLOUR_W-1:0] bg_colour,
    input  logic [ADDR_W-1:0]   x_base_addr,
    input  logic [ADDR_W-1:0]   y_base_addr,
    output logic [7:0]          ant_idx,
    input  logic                finished_dp,
    input  logic [RESULT_W-1:0] result_dp,
    output logic                start_dp,
    output logic [INSTR_W-1:0]  instruction_dp
);

    localparam int         IDX_W    = (NUM_ANTS > 1) ? $clog2(NUM_ANTS) : 1;
    localparam logic [7:0] LAST_IDX = 8'(NUM_ANTS - 1);

    draw_state_e                      state_q, state_d;
    logic                             finished_q, finished_d;
    logic [7:0]                       ant_idx_q, ant_idx_d;
    logic                             erase_en_q, erase_en_d;
    logic [COLOUR_W-1:0]              ant_colour_q, ant_colour_d;
    logic [COLOUR_W-1:0]              bg_colour_q, bg_colour_d;
    logic [ADDR_W-1:0]                x_base_q, x_base_d;
    logic [ADDR_W-1:0]                y_base_q, y_base_d;
    logic [X_W-1:0]                   x_q, x_d;
    logic [Y_W-1:0]                   y_q, y_d;
    logic [NUM_ANTS-1:0][X_W-1:0]     prev_x_q, prev_x_d;
    logic [NUM_ANTS-1:0][Y_W-1:0]     prev_y_q, prev_y_d;
    logic [NUM_ANTS-1:0]              prev_valid_q, prev_valid_d;

    logic                             req;
    logic [INSTR_W-1:0]               req_instr;
    logic                             dp_done;
    logic [RESULT_W-1:0]              dp_result;
    logic [IDX_W-1:0]                 idx;
    logic                             unused_result_hi;

    assign idx              = ant_idx_q[IDX_W-1:0];
    assign unused_result_hi = ^dp_result[RESULT_W-1:X_W];

    ant_dp_requester #(
        .INSTR_W  (INSTR_W),
        .RESULT_W (RESULT_W)
    ) u_req (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .instr          (req_instr),
        .done           (dp_done),
        .result         (dp_result),
        .start_dp       (start_dp),
        .instruction_dp (instruction_dp),
        .finished_dp    (finished_dp),
        .result_dp      (result_dp)
    );

    // Each transaction is requested on the edge that leaves the previous state,
    // so the ISSUE cycle coincides with the first cycle of the new state.
    always_comb begin
        state_d      = state_q;
        finished_d   = finished_q;
        ant_idx_d    = ant_idx_q;
        erase_en_d   = erase_en_q;
        ant_colour_d = ant_colour_q;
        bg_colour_d  = bg_colour_q;
        x_base_d     = x_base_q;
        y_base_d     = y_base_q;
        x_d          = x_q;
        y_d          = y_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        prev_valid_d = prev_valid_q;
        req          = 1'b0;
        req_instr    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    erase_en_d   = erase_en;
                    ant_colour_d = ant_colour;
                    bg_colour_d  = bg_colour;
                    x_base_d     = x_base_addr;
                    y_base_d     = y_base_addr;
                    ant_idx_d    = '0;
                    finished_d   = 1'b0;
                    state_d      = S_LOAD_X;
                    req          = 1'b1;
                    req_instr    = mk_load_instr(x_base_addr);
                end
            end
            S_LOAD_X: begin
                if (dp_done) begin
                    x_d       = dp_result[X_W-1:0];
                    state_d   = S_LOAD_Y;
                    req       = 1'b1;
                    req_instr = mk_load_instr(y_base_q + ADDR_W'(ant_idx_q));
                end
            end
            S_LOAD_Y: begin
                if (dp_done) begin
                    y_d = dp_result[Y_W-1:0];
                    req = 1'b1;
                    // An unmoved ant keeps its pixel; repainting it would only flicker.
                    if (erase_en_q && prev_valid_q[idx] &&
                        ((x_q != prev_x_q[idx]) || (y_d != prev_y_q[idx]))) begin
                        state_d   = S_ERASE;
                        req_instr = mk_plot_instr(bg_colour_q, prev_y_q[idx], prev_x_q[idx]);
                    end else begin
                        state_d   = S_DRAW;
                        req_instr = mk_plot_instr(ant_colour_q, y_d, x_q);
                    end
                end
            end
            S_ERASE: begin
                if (dp_done) begin
                    state_d   = S_DRAW;
                    req       = 1'b1;
                    req_instr = mk_plot_instr(ant_colour_q, y_q, x_q);
                end
            end
            S_DRAW: begin
                if (dp_done) begin
                    prev_x_d[idx]     = x_q;
                    prev_y_d[idx]     = y_q;
                    prev_valid_d[idx] = 1'b1;
                    state_d           = S_NEXT;
                end
            end
            S_NEXT: begin
                if (ant_idx_q == LAST_IDX) begin
                    state_d    = S_IDLE;
                    finished_d = 1'b1;
                end else begin
                    ant_idx_d = ant_idx_q + 8'd1;
                    state_d   = S_LOAD_X;
                    req       = 1'b1;
                    req_instr = mk_load_instr(x_base_q + ADDR_W'(ant_idx_d));
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            finished_q   <= 1'b1;
            ant_idx_q    <= '0;
            erase_en_q   <= 1'b0;
            ant_colour_q <= '0;
            bg_colour_q  <= '0;
            x_base_q     <= '0;
            y_base_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            finished_q   <= finished_d;
            ant_idx_q    <= ant_idx_d;
            erase_en_q   <= erase_en_d;
            ant_colour_q <= ant_colour_d;
            bg_colour_q  <= bg_colour_d;
            x_base_q     <= x_base_d;
            y_base_q     <= y_base_d;
            x_q          <= x_d;
            y_q          <= y_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign finished = finished_q;
    assign ant_idx  = ant_idx_q;

endmodule

// File: tb/tb_ant_swarm_draw.sv
// Randomized bench for ant_swarm_draw: a datapath responder with a memory model,
// and a frame-level reference model of the expected instruction stream and latency.
module tb_ant_swarm_draw;

    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        finished;
    logic        erase_en;
    logic [2:0]  ant_colour;
    logic [2:0]  bg_colour;
    logic [15:0] x_base_addr;
    logic [15:0] y_base_addr;
    logic [7:0]  ant_idx;
    logic        finished_dp;
    logic [31:0] result_dp;
    logic        start_dp;
    logic [31:0] instruction_dp;

    always #5 clock = ~clock;

    ant_swarm_draw #(.NUM_ANTS(N)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .finished       (finished),
        .erase_en       (erase_en),
        .ant_colour     (ant_colour),
        .bg_colour      (bg_colour),
        .x_base_addr    (x_base_addr),
        .y_base_addr    (y_base_addr),
        .ant_idx        (ant_idx),
        .finished_dp    (finished_dp),
        .result_dp      (result_dp),
        .start_dp       (start_dp),
        .instruction_dp (instruction_dp)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference state: memory image and each ant's last drawn pixel.
    logic [31:0] mem [logic [15:0]];
    logic [7:0]  px [N];
    logic [6:0]  py [N];
    bit          pv [N];

    logic [31:0] exp_q[$], obs_q[$];
    logic [7:0]  exp_idx[$], obs_idx[$];

    bit          cfg_er;
    logic [2:0]  cfg_col, cfg_bg;
    logic [15:0] cfg_xb, cfg_yb;
    int          dp_k = 0;
    bit          dp_glitch = 0;

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Datapath responder: logs each request, checks the handshake shape, and
    // answers dp_k cycles into WAIT; optional finished_dp noise during ISSUE/HOLD.
    initial begin : responder
        logic [31:0] cap;
        bit          aborted;
        finished_dp = 1'b0;
        result_dp   = '0;
        forever begin
            @(posedge clock); #1;
            while (start_dp === 1'b1 && !reset) begin
                cap = instruction_dp;
                obs_q.push_back(cap);
                obs_idx.push_back(ant_idx);
                finished_dp = dp_glitch;
                result_dp   = $urandom;
                @(posedge clock); #1;
                chk("hold_start", start_dp, 1);
                chk("hold_instr", instruction_dp, cap);
                finished_dp = dp_glitch;
                result_dp   = $urandom;
                @(posedge clock); #1;
                chk("wait_start", start_dp, 0);
                finished_dp = 1'b0;
                aborted     = 1'b0;
                for (int w = 0; w < dp_k; w++) begin
                    @(posedge clock); #1;
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted && !reset) begin
                    finished_dp = 1'b1;
                    result_dp   = (cap[31:28] == 4'd2) ? mem_rd(cap[15:0]) : $urandom;
                    @(posedge clock); #1;
                    finished_dp = 1'b0;
                end
            end
        end
    end

    task automatic fill_ants();
        for (int i = 0; i < N; i++) begin
            mem[cfg_xb + 16'(i)] = $urandom;
            mem[cfg_yb + 16'(i)] = $urandom;
        end
    endtask

    // Present config with start for one edge, then scramble the inputs to prove capture.
    task automatic pulse_start();
        obs_q.delete();
        obs_idx.delete();
        @(negedge clock);
        start       = 1'b1;
        erase_en    = cfg_er;
        ant_colour  = cfg_col;
        bg_colour   = cfg_bg;
        x_base_addr = cfg_xb;
        y_base_addr = cfg_yb;
        @(posedge clock); #1;
        start       = 1'b0;
        erase_en    = 1'($urandom);
        ant_colour  = 3'($urandom);
        bg_colour   = 3'($urandom);
        x_base_addr = 16'($urandom);
        y_base_addr = 16'($urandom);
    endtask

    task automatic run_frame(input int k, input bit gl, input string tag);
        int          exp_cyc, cyc, ntx;
        logic [31:0] w;
        logic [15:0] a;
        logic [7:0]  x;
        logic [6:0]  y;
        exp_q.delete();
        exp_idx.delete();
        exp_cyc = 1;
        for (int i = 0; i < N; i++) begin
            a = cfg_xb + 16'(i);
            w = mem_rd(a);
            x = w[7:0];
            exp_q.push_back({4'd2, 12'd0, a});
            a = cfg_yb + 16'(i);
            w = mem_rd(a);
            y = w[6:0];
            exp_q.push_back({4'd2, 12'd0, a});
            ntx = 3;
            if (cfg_er && pv[i] && (x != px[i] || y != py[i])) begin
                exp_q.push_back({4'd1, 9'd0, 1'b1, cfg_bg, py[i], px[i]});
                ntx = 4;
            end
            exp_q.push_back({4'd1, 9'd0, 1'b1, cfg_col, y, x});
            repeat (ntx) exp_idx.push_back(8'(i));
            px[i] = x;
            py[i] = y;
            pv[i] = 1'b1;
            exp_cyc += ntx * (3 + k) + 1;
        end
        dp_k      = k;
        dp_glitch = gl;
        pulse_start();
        chk({tag, "_busy"}, finished, 0);
        cyc = 1;
        while (!finished && cyc < 5000) begin
            @(posedge clock); #1;
            cyc++;
            start = (cyc >= 3 && cyc <= 6);
        end
        start = 1'b0;
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_ntx"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_instr"}, obs_q[i], exp_q[i]);
            chk({tag, "_idx"}, obs_idx[i], exp_idx[i]);
        end
        chk({tag, "_last_idx"}, ant_idx, N - 1);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; erase_en = 1'b0;
        ant_colour = '0; bg_colour = '0; x_base_addr = '0; y_base_addr = '0;
        for (int i = 0; i < N; i++) begin px[i] = '0; py[i] = '0; pv[i] = 1'b0; end
        repeat (3) @(posedge clock);
        #1;
        chk("rst_finished", finished, 1);
        chk("rst_start_dp", start_dp, 0);
        chk("rst_instr", instruction_dp, 0);
        chk("rst_ant_idx", ant_idx, 0);
        @(negedge clock) reset = 1'b0;

        // Erase pass over two frames: first frame has no history to erase.
        cfg_er = 1'b1; cfg_col = 3'd5; cfg_bg = 3'd2; cfg_xb = 16'h0100; cfg_yb = 16'h0200;
        fill_ants();
        mem[16'h0100] = 32'd3; mem[16'h0200] = 32'd4;
        run_frame(1, 0, "t3a");
        chk("t3a_no_erase", obs_q.size(), 12);
        mem[16'h0100] = 32'd6;
        run_frame(2, 0, "t3b");
        chk("t3b_ntx13", obs_q.size(), 13);
        chk("t3b_erase", (obs_q.size() > 3) ? obs_q[2] : 32'h0, {4'd1, 9'd0, 1'b1, 3'd2, 7'd4, 8'd3});
        chk("t3b_draw", (obs_q.size() > 3) ? obs_q[3] : 32'h0, {4'd1, 9'd0, 1'b1, 3'd5, 7'd4, 8'd6});

        // Nothing moved: no erase transactions at all.
        run_frame(0, 0, "t4");
        chk("t4_no_erase", obs_q.size(), 12);

        // Basic load/plot encoding.
        cfg_er = 1'b0; cfg_col = 3'd6; cfg_xb = 16'h0300; cfg_yb = 16'h0400;
        fill_ants();
        mem[16'h0300] = 32'd5; mem[16'h0400] = 32'd9;
        run_frame(1, 0, "t1");
        chk("t1_load_x", (obs_q.size() > 2) ? obs_q[0] : 32'h0, 32'h2000_0300);
        chk("t1_plot", (obs_q.size() > 2) ? obs_q[2] : 32'h0, {4'd1, 9'd0, 1'b1, 3'd6, 7'd9, 8'd5});

        // Address wrap at the top of memory.
        cfg_xb = 16'hFFFE; cfg_yb = 16'h0500;
        fill_ants();
        run_frame(0, 0, "t2");
        chk("t2_wrap", (obs_q.size() > 9) ? obs_q[9] : 32'h0, 32'h2000_0001);

        // Truncation of wide load results, with finished_dp noise in ISSUE/HOLD.
        cfg_xb = 16'h0600; cfg_yb = 16'h0700;
        fill_ants();
        mem[16'h0600] = 32'h0000_01FF;
        run_frame(2, 1, "t5");
        chk("t5_trunc", (obs_q.size() > 2) ? 32'(obs_q[2][7:0]) : 32'h0, 32'hFF);

        // Randomized frames; some repeat the previous placement to exercise the skip.
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 2) != 0) begin
                cfg_xb = 16'($urandom);
                cfg_yb = 16'($urandom);
                fill_ants();
            end
            cfg_er  = 1'($urandom);
            cfg_col = 3'($urandom);
            cfg_bg  = 3'($urandom);
            run_frame(int'($urandom_range(0, 3)), 1'($urandom), "rnd");
        end

        // Reset during the first DRAW wait, then a frame with erase enabled.
        cfg_er = 1'b0; cfg_xb = 16'h0800; cfg_yb = 16'h0900;
        fill_ants();
        dp_k = 8; dp_glitch = 1'b0;
        pulse_start();
        cyc = 0;
        while (obs_q.size() < 3 && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("t6_reach_draw", obs_q.size(), 3);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        chk("t6_start_dp", start_dp, 0);
        chk("t6_finished", finished, 1);
        chk("t6_ant_idx", ant_idx, 0);
        chk("t6_instr", instruction_dp, 0);
        @(negedge clock) reset = 1'b0;
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        cfg_er = 1'b1;
        mem[16'h0800] = mem_rd(16'h0800) ^ 32'h1;
        run_frame(1, 0, "t6b");
        chk("t6b_no_erase", obs_q.size(), 12);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
